// File: rtl/fm_op_sched.sv
// fm_op_sched: per-sample operator scheduler for the FM synthesis engine.
//
// Walks NUM_OPS operator slots of OP_CYCLES clocks each and drives the shared
// envelope-generator datapath behind the operator-state RAM. It also keeps
// the per-operator key-on history, runs the post-reset clear sweep, and owns
// the tremolo (AM) LFO.
//
// Ports:
//   clk, rst      - system clock; synchronous active-high reset
//   sample_start  - one-clock pulse requesting a full operator pass
//   soft_clear    - one-clock pulse requesting a clear sweep of all operators
//   kon           - key-on of the operator addressed by op_sel (combinational)
//   am_depth      - tremolo depth: 1 = deep, 0 = shallow
//   op_sel        - current operator index
//   next          - write-back strobe, last cycle of each slot
//   op_reset      - force addressed operator to release/max attenuation
//   restart       - force addressed operator into attack
//   am_val        - tremolo attenuation offset, constant within a pass
//   busy          - a pass or sweep is in progress
//   done          - one-clock pulse after the final write-back of a RUN pass
//   overrun       - sticky: a run request arrived while one was already queued
//   fsm_state     - debug view of the scheduler state (0 idle, 1 clear, 2 run)
//
// Request/strobe semantics: sample_start and soft_clear are single-cycle
// pulses with no ready; they are always accepted. A request that cannot start
// immediately is latched as pending (one deep per kind) and launched at the
// next pass boundary with no idle gap. next, done are single-cycle strobes.
module fm_op_sched #(
  parameter int NUM_OPS   = 36,
  parameter int OP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_start,
  input  logic       soft_clear,
  input  logic       kon,
  input  logic       am_depth,
  output logic [5:0] op_sel,
  output logic       next,
  output logic       op_reset,
  output logic       restart,
  output logic [5:0] am_val,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic [1:0] fsm_state
);

  localparam int IW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam logic [3:0] SLOT_LAST = 4'(OP_CYCLES - 1);
  localparam logic [5:0] OP_LAST   = 6'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t             state;
  logic [3:0]         slot_cnt;
  logic [NUM_OPS-1:0] kon_hist;
  logic               pend_run;
  logic               pend_clr;
  logic [5:0]         am_div;
  logic [5:0]         am_pos;
  logic [5:0]         tri_val;
  logic [IW-1:0]      idx;

  assign idx       = op_sel[IW-1:0];
  assign busy      = (state != S_IDLE);
  assign next      = busy && (slot_cnt == SLOT_LAST);
  assign op_reset  = (state == S_CLEAR);
  // Key-on edge detect against the history written at the previous pass.
  assign restart   = (state == S_RUN) && kon && !kon_hist[idx];
  assign fsm_state = state;

  // Triangle over am_pos 0..51: rises 0..25, falls back 25..0.
  assign tri_val = (am_pos < 6'd26) ? am_pos : (6'd51 - am_pos);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLEAR;
      slot_cnt <= '0;
      op_sel   <= '0;
      kon_hist <= '0;
      pend_run <= 1'b0;
      pend_clr <= 1'b0;
      overrun  <= 1'b0;
      done     <= 1'b0;
      am_div   <= '0;
      am_pos   <= '0;
      am_val   <= '0;
    end else begin
      done <= 1'b0;
      // Only refreshed between passes so every operator of a pass sees the
      // same tremolo offset.
      if (state == S_IDLE) begin
        am_val <= am_depth ? tri_val : (tri_val >> 2);
      end
      case (state)
        S_IDLE: begin
          if (soft_clear || pend_clr) begin
            state    <= S_CLEAR;
            pend_clr <= 1'b0;
            if (sample_start) pend_run <= 1'b1;
          end else if (sample_start || pend_run) begin
            state    <= S_RUN;
            pend_run <= 1'b0;
          end
        end
        default: begin
          if (soft_clear) pend_clr <= 1'b1;
          if (sample_start) begin
            if (pend_run) overrun <= 1'b1;
            pend_run <= 1'b1;
          end
          if (next) begin
            slot_cnt      <= '0;
            kon_hist[idx] <= (state == S_RUN) ? kon : 1'b0;
            if (op_sel == OP_LAST) begin
              op_sel <= '0;
              if (state == S_RUN) begin
                done   <= 1'b1;
                am_div <= am_div + 6'd1;
                if (am_div == 6'd63) begin
                  am_pos <= (am_pos == 6'd51) ? 6'd0 : am_pos + 6'd1;
                end
              end
              // Pass boundary: clear outranks run; a queued run survives a
              // clear and is launched after it. The later assignments here
              // override the request latching above.
              if (pend_clr || soft_clear) begin
                state    <= S_CLEAR;
                pend_clr <= 1'b0;
              end else if (pend_run || sample_start) begin
                state    <= S_RUN;
                pend_run <= pend_run && sample_start;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              op_sel <= op_sel + 6'd1;
            end
          end else begin
            slot_cnt <= slot_cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fm_op_sched.md
# fm_op_sched

Per-sample operator scheduler for the FM synthesis engine. On each sample strobe it walks the operator slots in order and drives the shared envelope-generator datapath, which sits behind a single operator-state RAM. For each slot it drives `op_sel`, the `next` write-back strobe, and the `restart` and `op_reset` controls. It also owns the per-operator key-on history, the post-reset clear sweep and the tremolo (AM) LFO that feeds `am_val`.

## Interface
- `NUM_OPS`, 36: operator slots per sample; legal range 2..64.
- `OP_CYCLES`, 4: clocks per operator slot; legal range 2..16. The datapath reads state in cycle 0 and writes it back in cycle `OP_CYCLES-1`.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous reset, active-high.
- `sample_start` in 1: one-clock pulse requesting a full operator pass.
- `soft_clear` in 1: one-clock pulse requesting a clear sweep of all operators.
- `kon` in 1: key-on of the operator addressed by `op_sel`; combinational from the register file; valid in every slot cycle.
- `am_depth` in 1: tremolo depth select; 1 = deep, 0 = shallow.
- `op_sel` out 6: current operator index.
- `next` out 1: write-back strobe for operator state.
- `op_reset` out 1: forces the addressed operator to release with maximum attenuation.
- `restart` out 1: forces the addressed operator into the attack stage.
- `am_val` out 6: tremolo attenuation offset.
- `busy` out 1: high while a pass or sweep is in progress.
- `done` out 1: one-clock pulse at the end of a normal pass.
- `overrun` out 1: sticky flag; cleared only by `rst`.

## Operation
- States:
  - IDLE: waiting for work.
  - CLEAR: sweep of all `NUM_OPS` slots with `op_reset`=1 and `restart`=0.
  - RUN: normal pass over all `NUM_OPS` slots.
- Counters:
  - `slot_cnt` counts 0..`OP_CYCLES-1`.
  - `op_sel` counts 0..`NUM_OPS-1`.
  - Both wrap to 0 at the end of each pass.
- `next` = 1 when `slot_cnt == OP_CYCLES-1` in CLEAR or RUN; 0 otherwise.
- Slot advance:
  - At `next`, `op_sel` increments.
  - At `next` in the last slot, the state returns to IDLE (or restarts, see pending handling) and `op_sel` returns to 0.
- Key-on history is a `NUM_OPS`-bit register `kon_hist`.
  - `restart` = `kon & ~kon_hist[op_sel]`, qualified by state RUN. It is held for the whole slot.
  - At `next` in RUN, `kon_hist[op_sel] <= kon`.
  - At `next` in CLEAR, `kon_hist[op_sel] <= 0`.
- Pending requests:
  - `sample_start` is accepted from IDLE.
  - A `sample_start` arriving in RUN or CLEAR sets `pend_run`. A second one while `pend_run` is already set sets `overrun`.
  - `soft_clear` in any state sets `pend_clr`.
  - Exit priority, from IDLE or at the end of a pass: `pend_clr` first (to CLEAR), then `pend_run` or same-cycle `sample_start` (to RUN), otherwise IDLE.
  - A clear that is running to completion discards nothing: `pend_run` is kept.
- Reset: `rst` forces state CLEAR (a full sweep runs automatically) and sets `op_sel`=0, `slot_cnt`=0, `kon_hist`=0, `pend_*`=0, `overrun`=0 and the LFO registers to 0.
- `done` pulses in the cycle after the final `next` of a RUN. It never pulses after CLEAR.
- Tremolo LFO:
  - `am_div` is a 6-bit counter that increments once per completed RUN.
  - When `am_div` wraps, `am_pos` (0..51) increments and wraps from 51 to 0.
  - Triangle value: `tri` = `am_pos` when `am_pos` < 26, otherwise 51−`am_pos`. The range is 0..25.
  - `am_val` = `am_depth ? tri : tri>>2`. It is registered and updates only when `busy`=0, so it is constant within a pass.

## Timing
- Reset values:
  - `op_sel`=0, `next`=0, `restart`=0, `am_val`=0, `done`=0, `overrun`=0.
  - `busy`=1 and `op_reset`=1, because the state is CLEAR.
- RUN latency: after `sample_start` in IDLE at cycle T, RUN starts at T+1.
- Pass length: `NUM_OPS*OP_CYCLES` cycles (144 with defaults).
  - Final `next` at T+144.
  - `done` and `busy`=0 at T+145.
  - A pending run starts at T+145 with no IDLE cycle; in that case `busy` stays 1.
- Slot outputs:
  - `op_sel`, `restart` and `op_reset` change only on slot boundaries and are stable for all `OP_CYCLES` cycles of a slot.
  - `am_val` is stable for the whole pass.
- Simultaneous events:
  - `rst` with anything: reset wins.
  - `soft_clear` and `sample_start` in the same IDLE cycle: CLEAR runs first, then RUN.

## Test plan
- Reset sweep:
  - Stimulus: assert `rst` for 1 cycle.
  - Response: 36 `next` pulses with `op_reset`=1 and `op_sel` 0..35, each 4 cycles apart; then `busy`=0 and no `done`.
- Single pass:
  - Stimulus: `sample_start` in IDLE with `kon`=0.
  - Response: `done` exactly 145 cycles later; 36 `next` pulses; `restart`=0 throughout.
- Key-on edge:
  - Stimulus: `kon`=1 for op 5 only, over 2 passes.
  - Response: `restart`=1 only during op 5's slot of pass 1, and 0 in pass 2.
  - Follow-up: drop `kon`, then raise it again; `restart` fires again.
- Back-to-back and overrun:
  - Stimulus: `sample_start` at cycles 10 and 60 of a RUN.
  - Response: the second RUN starts with no gap; `overrun`=1 and stays set.
- Clear priority:
  - Stimulus: `soft_clear` mid-RUN plus a pending `sample_start`.
  - Response: the RUN completes, then a CLEAR runs, then a RUN; `kon_hist` is zeroed, so a held `kon` produces `restart`.
- LFO:
  - Stimulus: 64×52 passes with `am_depth`=1.
  - Response: `am_val` ramps 0→25→0 once, with step changes only when `busy`=0.
  - With `am_depth`=0: peak `am_val` is 6.
